// File: rtl/ysyx_23060124_ifu.sv
// Instruction fetch unit: one single-beat AXI4-Lite read per PC, handed to decode via valid/ready.
// Optional performance counters are built when YSYX_23060124_IFU_PERF_EN is defined.
module ysyx_23060124_ifu #(
  parameter int                   ISA_WIDTH = 32,
  parameter logic [ISA_WIDTH-1:0] NOP_INST  = 32'h0000_0013
) (
  input  logic                 clk,
  input  logic                 i_rst_ifu,
  input  logic [ISA_WIDTH-1:0] i_pc,
  input  logic                 i_pc_update,
  output logic [ISA_WIDTH-1:0] o_araddr,
  output logic                 o_arvalid,
  input  logic                 i_arready,
  input  logic [ISA_WIDTH-1:0] i_rdata,
  input  logic [1:0]           i_rresp,
  input  logic                 i_rvalid,
  output logic                 o_rready,
  output logic [ISA_WIDTH-1:0] o_inst,
  output logic [ISA_WIDTH-1:0] o_pc,
  output logic                 o_ifu_err,
  output logic                 o_ifu_valid,
  input  logic                 i_idu_ready,
  output logic                 o_ifu_busy,
  output logic [31:0]          o_perf_fetch_cnt,
  output logic [31:0]          o_perf_stall_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_AR    = 2'd1;
  localparam logic [1:0] S_R     = 2'd2;
  localparam logic [1:0] S_VALID = 2'd3;

  logic [1:0]           state_q, state_d;
  logic                 boot_q, boot_d;
  logic                 arvalid_q, arvalid_d;
  logic                 rready_q, rready_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;
  logic [ISA_WIDTH-1:0] inst_q, inst_d;
  logic [ISA_WIDTH-1:0] pc_q, pc_d;
  logic [ISA_WIDTH-1:0] araddr_q, araddr_d;
  logic                 start;

  always_comb begin
    state_d   = state_q;
    boot_d    = boot_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    valid_d   = valid_q;
    err_d     = err_q;
    inst_d    = inst_q;
    pc_d      = pc_q;
    araddr_d  = araddr_q;
    start     = 1'b0;

    case (state_q)
      S_IDLE: start = boot_q | i_pc_update;
      S_AR: begin
        if (i_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_R;
        end
      end
      S_R: begin
        if (i_rvalid) begin
          inst_d   = i_rdata;
          err_d    = (i_rresp != 2'b00);
          rready_d = 1'b0;
          valid_d  = 1'b1;
          state_d  = S_VALID;
        end
      end
      default: begin
        if (i_idu_ready) begin
          valid_d = 1'b0;
          if (i_pc_update) start = 1'b1;
          else             state_d = S_IDLE;
        end
      end
    endcase

    // A misaligned PC never reaches the bus; it is reported as a faulting NOP.
    if (start) begin
      pc_d     = i_pc;
      araddr_d = i_pc;
      boot_d   = 1'b0;
      if (i_pc[1:0] == 2'b00) begin
        state_d   = S_AR;
        arvalid_d = 1'b1;
      end else begin
        state_d = S_VALID;
        inst_d  = NOP_INST;
        err_d   = 1'b1;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst_ifu) begin
      state_q   <= S_IDLE;
      boot_q    <= 1'b1;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      inst_q    <= '0;
      pc_q      <= '0;
      araddr_q  <= '0;
    end else begin
      state_q   <= state_d;
      boot_q    <= boot_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      inst_q    <= inst_d;
      pc_q      <= pc_d;
      araddr_q  <= araddr_d;
    end
  end

  assign o_araddr    = araddr_q;
  assign o_arvalid   = arvalid_q;
  assign o_rready    = rready_q;
  assign o_inst      = inst_q;
  assign o_pc        = pc_q;
  assign o_ifu_err   = err_q;
  assign o_ifu_valid = valid_q;
  assign o_ifu_busy  = (state_q != S_IDLE);

`ifdef YSYX_23060124_IFU_PERF_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  // Counters wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (i_rst_ifu) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (state_q == S_R && i_rvalid)            fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (state_q == S_AR || state_q == S_R)     stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign o_perf_fetch_cnt = fetch_cnt_q;
  assign o_perf_stall_cnt = stall_cnt_q;
`else
  assign o_perf_fetch_cnt = 32'h0;
  assign o_perf_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_ysyx_23060124_ifu.sv
// Scoreboard bench for ysyx_23060124_ifu: driver pushes expected fetch results, monitor pops and compares.
module tb_ysyx_23060124_ifu;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        i_rst_ifu = 1'b1;
  logic [31:0] i_pc = 32'h0;
  logic        i_pc_update = 1'b0;
  logic [31:0] o_araddr;
  logic        o_arvalid;
  logic        i_arready = 1'b0;
  logic [31:0] i_rdata = 32'h0;
  logic [1:0]  i_rresp = 2'b00;
  logic        i_rvalid = 1'b0;
  logic        o_rready;
  logic [31:0] o_inst;
  logic [31:0] o_pc;
  logic        o_ifu_err;
  logic        o_ifu_valid;
  logic        i_idu_ready = 1'b0;
  logic        o_ifu_busy;
  logic [31:0] o_perf_fetch_cnt;
  logic [31:0] o_perf_stall_cnt;

  ysyx_23060124_ifu dut (
    .clk              (clk),
    .i_rst_ifu        (i_rst_ifu),
    .i_pc             (i_pc),
    .i_pc_update      (i_pc_update),
    .o_araddr         (o_araddr),
    .o_arvalid        (o_arvalid),
    .i_arready        (i_arready),
    .i_rdata          (i_rdata),
    .i_rresp          (i_rresp),
    .i_rvalid         (i_rvalid),
    .o_rready         (o_rready),
    .o_inst           (o_inst),
    .o_pc             (o_pc),
    .o_ifu_err        (o_ifu_err),
    .o_ifu_valid      (o_ifu_valid),
    .i_idu_ready      (i_idu_ready),
    .o_ifu_busy       (o_ifu_busy),
    .o_perf_fetch_cnt (o_perf_fetch_cnt),
    .o_perf_stall_cnt (o_perf_stall_cnt)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
    int unsigned start;
    int unsigned lat;
    logic [31:0] stall;
    logic [31:0] fetch;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] sum_stall = 0;
  logic [31:0] sum_fetch = 0;
  int          ar_wait = 0;
  int          r_wait = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out at cycle %0d", nm, cyc);
  endtask

  // Instruction memory contents.
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0010_0093;
    if (a == 32'h8000_0100) return 32'hDEAD_BEEF;
    return a ^ {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  function automatic logic [1:0] mem_resp(input logic [31:0] a);
    if (a == 32'h8000_0100) return 2'b10;
    if (a[5:2] == 4'hF)     return 2'b10;
    if (a[5:2] == 4'hE)     return 2'b11;
    return 2'b00;
  endfunction

  // Reference: what a fetch of pc must deliver, and when.
  task automatic issue(input logic [31:0] pc, input int arw, input int rw, input bit is_boot);
    exp_t e;
    i_pc        = pc;
    i_pc_update = !is_boot;
    ar_wait     = arw;
    r_wait      = rw;
    e.pc    = pc;
    e.start = cyc + 1;
    if (pc[1:0] != 2'b00) begin
      e.inst = NOP;
      e.err  = 1'b1;
      e.lat  = 0;
    end else begin
      e.inst    = mem_data(pc);
      e.err     = (mem_resp(pc) != 2'b00);
      e.lat     = 2 + arw + rw;
      sum_stall = sum_stall + 32'(2 + arw + rw);
      sum_fetch = sum_fetch + 32'd1;
    end
    e.stall = sum_stall;
    e.fetch = sum_fetch;
    sb.push_back(e);
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!o_ifu_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!o_ifu_valid) timeout("wait_valid");
  endtask

  task automatic wait_idle();
    int t = 0;
    while (o_ifu_busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (o_ifu_busy) timeout("wait_idle");
  endtask

  task automatic hold_ready(input int stall_n);
    for (int k = 0; k < stall_n; k++) begin
      i_idu_ready = 1'b0;
      @(negedge clk);
    end
    i_idu_ready = 1'b1;
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] p;
    p = 32'h8000_0000 | (32'($urandom_range(0, 255)) << 2);
    if ($urandom_range(0, 3) == 0) p = p | 32'($urandom_range(1, 3));
    return p;
  endfunction

  // Memory responder with per-fetch programmable wait states.
  initial begin
    int          ar_cnt = 0;
    int          r_cnt = 0;
    logic [31:0] r_addr = 0;
    forever begin
      @(negedge clk);
      if (o_arvalid) begin
        if (ar_cnt < ar_wait) begin
          i_arready = 1'b0;
          ar_cnt++;
        end else begin
          i_arready = 1'b1;
          ar_cnt    = 0;
          r_addr    = o_araddr;
        end
      end else begin
        i_arready = 1'b0;
        ar_cnt    = 0;
      end
      if (o_rready) begin
        if (r_cnt < r_wait) begin
          i_rvalid = 1'b0;
          i_rdata  = $urandom;
          i_rresp  = 2'($urandom);
          r_cnt++;
        end else begin
          i_rvalid = 1'b1;
          i_rdata  = mem_data(r_addr);
          i_rresp  = mem_resp(r_addr);
          r_cnt    = 0;
        end
      end else begin
        i_rvalid = 1'b0;
        i_rdata  = $urandom;
        r_cnt    = 0;
      end
    end
  end

  // Monitor: compares presented fetch results against the scoreboard.
  initial begin
    bit   seen_first = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (i_rst_ifu) begin
        seen_first = 0;
      end else begin
        if (o_arvalid) begin
          if (sb.size() == 0) timeout("arvalid_without_request");
          else begin
            chk("araddr", o_araddr, sb[0].pc);
            chk("arvalid_aligned_pc", 32'(sb[0].pc[1:0]), 32'h0);
          end
        end
        if (o_ifu_valid) begin
          if (sb.size() == 0) timeout("valid_without_request");
          else begin
            e = sb[0];
            chk("o_pc", o_pc, e.pc);
            chk("o_inst", o_inst, e.inst);
            chk("o_ifu_err", 32'(o_ifu_err), 32'(e.err));
            if (!seen_first) begin
              chk("valid_latency", cyc, e.start + e.lat);
`ifdef YSYX_23060124_IFU_PERF_EN
              chk("perf_stall", o_perf_stall_cnt, e.stall);
              chk("perf_fetch", o_perf_fetch_cnt, e.fetch);
`else
              chk("perf_stall_tied", o_perf_stall_cnt, 32'h0);
              chk("perf_fetch_tied", o_perf_fetch_cnt, 32'h0);
`endif
              seen_first = 1;
            end
            if (i_idu_ready) begin
              void'(sb.pop_front());
              seen_first = 0;
            end
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit pending;
    repeat (3) @(negedge clk);
    chk("rst_arvalid", 32'(o_arvalid), 32'h0);
    chk("rst_rready", 32'(o_rready), 32'h0);
    chk("rst_valid", 32'(o_ifu_valid), 32'h0);
    chk("rst_err", 32'(o_ifu_err), 32'h0);
    chk("rst_inst", o_inst, 32'h0);
    chk("rst_pc", o_pc, 32'h0);
    chk("rst_araddr", o_araddr, 32'h0);
    chk("rst_busy", 32'(o_ifu_busy), 32'h0);
    chk("rst_perf_fetch", o_perf_fetch_cnt, 32'h0);
    chk("rst_perf_stall", o_perf_stall_cnt, 32'h0);

    // Boot fetch: boot flag starts the first fetch without i_pc_update.
    i_rst_ifu = 1'b0;
    issue(32'h8000_0000, 0, 0, 1'b1);
    wait_valid();
    hold_ready(0);
    @(negedge clk);
    i_idu_ready = 1'b0;

    // Backpressure, bus error, misaligned.
    wait_idle();
    issue(32'h8000_0008, 2, 3, 1'b0);
    @(negedge clk);
    i_pc_update = 1'b0;
    wait_valid();
    hold_ready(1);
    @(negedge clk);
    i_idu_ready = 1'b0;

    wait_idle();
    issue(32'h8000_0100, 0, 0, 1'b0);
    @(negedge clk);
    i_pc_update = 1'b0;
    wait_valid();
    hold_ready(0);
    @(negedge clk);
    i_idu_ready = 1'b0;

    wait_idle();
    issue(32'h8000_0002, 0, 0, 1'b0);
    @(negedge clk);
    i_pc_update = 1'b0;
    wait_valid();
    hold_ready(0);
    @(negedge clk);
    i_idu_ready = 1'b0;

    // Decode stall then chained fetch in the handshake cycle.
    wait_idle();
    issue(32'h8000_0040, 1, 0, 1'b0);
    @(negedge clk);
    i_pc_update = 1'b0;
    wait_valid();
    hold_ready(4);
    issue(32'h8000_0004, 0, 0, 1'b0);
    @(negedge clk);
    i_pc_update = 1'b0;
    i_idu_ready = 1'b0;
    wait_valid();
    hold_ready(0);
    @(negedge clk);
    i_idu_ready = 1'b0;

    // Randomized traffic with optional chaining.
    pending = 0;
    for (int i = 0; i < 60; i++) begin
      if (!pending) begin
        wait_idle();
        issue(rand_pc(), $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
        @(negedge clk);
        i_pc_update = 1'b0;
      end
      wait_valid();
      hold_ready($urandom_range(0, 2));
      if (i < 59 && $urandom_range(0, 1) == 1) begin
        issue(rand_pc(), $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
        pending = 1;
      end else begin
        pending = 0;
      end
      @(negedge clk);
      i_pc_update = 1'b0;
      i_idu_ready = 1'b0;
    end

    // Reset while waiting for read data.
    wait_idle();
    issue(32'h8000_0010, 0, 5, 1'b0);
    @(negedge clk);
    i_pc_update = 1'b0;
    begin
      int t = 0;
      while (!o_rready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (!o_rready) timeout("wait_rready");
    end
    i_rst_ifu = 1'b1;
    i_pc      = 32'h8000_0020;
    @(negedge clk);
    chk("midrst_rready", 32'(o_rready), 32'h0);
    chk("midrst_busy", 32'(o_ifu_busy), 32'h0);
    chk("midrst_arvalid", 32'(o_arvalid), 32'h0);
    chk("midrst_valid", 32'(o_ifu_valid), 32'h0);
    chk("midrst_perf_fetch", o_perf_fetch_cnt, 32'h0);
    chk("midrst_perf_stall", o_perf_stall_cnt, 32'h0);
    sb.delete();
    sum_stall = 0;
    sum_fetch = 0;
    i_rst_ifu = 1'b0;
    issue(32'h8000_0020, 0, 0, 1'b1);
    wait_valid();
    hold_ready(0);
    @(negedge clk);
    i_idu_ready = 1'b0;

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
